freq_meter_recip: RTL and testbench

Parametrised reciprocal (equal-precision) frequency meter, successor to the fixed 200 MHz / 2 s gate meter. It counts whole `sig_in` periods and `sys_clk` cycles over a gate that opens and closes on `sig_in` rising edges, so f = F_sys × sig_cnt / ref_cnt regardless of input phase. It adds selectable single/continuous mode, timeout on a dead input, counter saturation flags and a valid/ready result handshake, and sits between the input conditioning and the measurement readout/UART path.

---
 rtl/freq_meter_recip.sv | 144 ++++++++++++++
 tb/tb_freq_meter_recip.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_recip.sv
// Reciprocal frequency meter: counts whole sig_in periods and sys_clk cycles over a gate aligned to sig_in rising edges.
// Optional macro FREQ_METER_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector for asynchronous sig_in.
module freq_meter_recip #(
  parameter int              CNT_W          = 32,
  parameter longint unsigned GATE_CYCLES    = 200_000_000,
  parameter longint unsigned TIMEOUT_CYCLES = 400_000_000,
  parameter bit              CONTINUOUS     = 1'b1
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] sig_cnt,
  output logic [CNT_W-1:0] ref_cnt,
  output logic             ovf,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} state_t;

  localparam logic [CNT_W:0]   GATE_LIM  = GATE_CYCLES[CNT_W:0];
  localparam logic [CNT_W:0]   TO_LIM    = TIMEOUT_CYCLES[CNT_W:0];
  localparam logic [CNT_W:0]   TOTAL_LIM = GATE_LIM + TO_LIM;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic             sig_src;
  logic             d0, d1;
  logic             sig_edge;
  logic [CNT_W:0]   timer;
  logic [CNT_W:0]   timer_nxt;
  logic [CNT_W-1:0] acc_sig, acc_ref;
  logic [CNT_W-1:0] sig_nxt, ref_nxt;
  logic             acc_ovf, ovf_nxt;

`ifdef FREQ_METER_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

  assign sig_src = sync2;
`else
  assign sig_src = sig_in;
`endif

  assign sig_edge = d0 & ~d1;

  // Timer runs at CNT_W+1 bits so it keeps measuring elapsed gate time after ref_cnt saturates.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    timer_nxt = timer + (CNT_W + 1)'(1);
    ref_nxt   = acc_ref;
    sig_nxt   = acc_sig;
    ovf_nxt   = acc_ovf;
    if (acc_ref == CNT_MAX) ovf_nxt = 1'b1;
    else                    ref_nxt = acc_ref + CNT_W'(1);
    if (sig_edge) begin
      if (acc_sig == CNT_MAX) ovf_nxt = 1'b1;
      else                    sig_nxt = acc_sig + CNT_W'(1);
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      d0         <= 1'b0;
      d1         <= 1'b0;
      timer      <= '0;
      acc_sig    <= '0;
      acc_ref    <= '0;
      acc_ovf    <= 1'b0;
      meas_valid <= 1'b0;
      sig_cnt    <= '0;
      ref_cnt    <= '0;
      ovf        <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      d0 <= sig_src;
      d1 <= d0;
      unique case (state)
        IDLE: if (CONTINUOUS || start) begin
          state <= ARM;
          timer <= '0;
          busy  <= 1'b1;
        end
        ARM: if (sig_edge) begin
          // An edge coinciding with the ARM timeout still opens the gate.
          state   <= GATE;
          timer   <= '0;
          acc_sig <= '0;
          acc_ref <= '0;
          acc_ovf <= 1'b0;
        end else if (timer_nxt >= TO_LIM) begin
          state      <= HOLD;
          busy       <= 1'b0;
          meas_valid <= 1'b1;
          sig_cnt    <= '0;
          ref_cnt    <= '0;
          ovf        <= 1'b0;
          timeout    <= 1'b1;
        end else begin
          timer <= timer_nxt;
        end
        GATE: begin
          timer   <= timer_nxt;
          acc_sig <= sig_nxt;
          acc_ref <= ref_nxt;
          acc_ovf <= ovf_nxt;
          // Close is tested first so it beats a timeout falling on the same cycle.
          if ((sig_edge && timer_nxt >= GATE_LIM) || timer_nxt >= TOTAL_LIM) begin
            state      <= HOLD;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            sig_cnt    <= sig_nxt;
            ref_cnt    <= ref_nxt;
            ovf        <= ovf_nxt;
            timeout    <= !(sig_edge && timer_nxt >= GATE_LIM);
          end
        end
        HOLD: if (meas_ready) begin
          meas_valid <= 1'b0;
          timer      <= '0;
          state      <= CONTINUOUS ? ARM : IDLE;
          busy       <= CONTINUOUS;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_recip.sv
// Directed bench for freq_meter_recip: three instances (continuous, single-shot, 8-bit saturation) share one stimulus.
module tb_freq_meter_recip;

  logic clk = 1'b0;
  logic rst_n, sig_in, start, meas_ready;

  logic m_valid, m_ovf, m_to, m_busy;
  logic [15:0] m_sig, m_ref;
  logic c_valid, c_ovf, c_to, c_busy;
  logic [15:0] c_sig, c_ref;
  logic s_valid, s_ovf, s_to, s_busy;
  logic [7:0] s_sig, s_ref;

  int n_checks = 0;
  int n_pass   = 0;
  int gen_period = 10;
  int gen_ph     = 0;
  int gen_left   = 0;

  always #5 clk = ~clk;

  freq_meter_recip #(.CNT_W(16), .GATE_CYCLES(100), .TIMEOUT_CYCLES(50), .CONTINUOUS(1'b1)) dut_m (
    .sys_clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .meas_valid(m_valid), .sig_cnt(m_sig), .ref_cnt(m_ref), .ovf(m_ovf), .timeout(m_to), .busy(m_busy));

  freq_meter_recip #(.CNT_W(16), .GATE_CYCLES(100), .TIMEOUT_CYCLES(50), .CONTINUOUS(1'b0)) dut_c (
    .sys_clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .meas_valid(c_valid), .sig_cnt(c_sig), .ref_cnt(c_ref), .ovf(c_ovf), .timeout(c_to), .busy(c_busy));

  freq_meter_recip #(.CNT_W(8), .GATE_CYCLES(200), .TIMEOUT_CYCLES(100), .CONTINUOUS(1'b1)) dut_s (
    .sys_clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .meas_valid(s_valid), .sig_cnt(s_sig), .ref_cnt(s_ref), .ovf(s_ovf), .timeout(s_to), .busy(s_busy));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock; sig_in emits a 1-cycle pulse every gen_period cycles while pulses remain (-1 = endless).
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_left != 0) begin
      sig_in = (gen_ph == 0);
      if (gen_ph == 0 && gen_left > 0) gen_left--;
      gen_ph = (gen_ph + 1 >= gen_period) ? 0 : gen_ph + 1;
    end else begin
      sig_in = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic gen(input int period, input int count);
    gen_period = period;
    gen_ph     = 0;
    gen_left   = count;
  endtask

  task automatic do_reset();
    gen_left = 0;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  function automatic logic valid_of(input int which);
    case (which)
      0:       return m_valid;
      1:       return c_valid;
      default: return s_valid;
    endcase
  endfunction

  task automatic wait_valid(input string tag, input int which, input int budget, output int n);
    n = 0;
    while (!valid_of(which) && n < budget) begin
      tick();
      n++;
    end
    check({tag, " valid"}, valid_of(which), 1);
  endtask

  initial begin
    int n;
    int err;
    rst_n = 1'b0; sig_in = 1'b0; start = 1'b0; meas_ready = 1'b1;

    // Reset state
    ticks(3);
    check("rst valid", m_valid, 0);
    check("rst sig", m_sig, 0);
    check("rst ref", m_ref, 0);
    check("rst ovf", m_ovf, 0);
    check("rst timeout", m_to, 0);
    check("rst busy", m_busy, 0);

    // Dead input: 1 IDLE cycle + 50 ARM cycles, then an empty timeout result
    rst_n = 1'b1;
    wait_valid("arm_to", 0, 200, n);
    check("arm_to cycles", n, 51);
    check("arm_to sig", m_sig, 0);
    check("arm_to ref", m_ref, 0);
    check("arm_to timeout", m_to, 1);
    check("arm_to ovf", m_ovf, 0);
    check("arm_to busy", m_busy, 0);
    check("single idle busy", c_busy, 0);
    tick();
    check("arm_to valid 1 cycle", m_valid, 0);

    // Period 10, two consecutive results
    do_reset();
    gen(10, -1);
    wait_valid("p10a", 0, 400, n);
    check("p10a sig", m_sig, 10);
    check("p10a ref", m_ref, 100);
    check("p10a ovf", m_ovf, 0);
    check("p10a timeout", m_to, 0);
    tick();
    wait_valid("p10b", 0, 400, n);
    check("p10b sig", m_sig, 10);
    check("p10b ref", m_ref, 100);

    // Period 7
    do_reset();
    gen(7, -1);
    wait_valid("p7", 0, 400, n);
    check("p7 sig", m_sig, 15);
    check("p7 ref", m_ref, 105);
    check("p7 timeout", m_to, 0);

    // Back-pressure: result held while sig_in keeps toggling
    do_reset();
    gen(10, -1);
    meas_ready = 1'b0;
    wait_valid("hold", 0, 400, n);
    err = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!m_valid || m_sig != 16'd10 || m_ref != 16'd100 || m_busy) err++;
    end
    check("hold stable errors", err, 0);
    meas_ready = 1'b1;
    tick();
    check("hold drop", m_valid, 0);

    // Reset in the middle of a gate
    tick();
    wait_valid("pre_rst", 0, 400, n);
    ticks(20);
    check("pre_rst sig held", m_sig, 10);
    rst_n = 1'b0;
    tick();
    check("mid_rst valid", m_valid, 0);
    check("mid_rst sig", m_sig, 0);
    check("mid_rst ref", m_ref, 0);
    check("mid_rst busy", m_busy, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rst rearm busy", m_busy, 1);

    // Single-shot instance arms only on start
    ticks(60);
    check("single no arm busy", c_busy, 0);
    check("single no arm valid", c_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("single start busy", c_busy, 1);
    wait_valid("single", 1, 400, n);
    check("single sig", c_sig, 10);
    check("single ref", c_ref, 100);
    tick();
    check("single back idle", c_busy, 0);
    ticks(30);
    check("single stays idle", c_busy, 0);

    // Input dies inside the gate: timeout at 150 elapsed cycles
    do_reset();
    ticks(5);
    gen(10, 5);
    wait_valid("gate_to", 0, 400, n);
    check("gate_to sig", m_sig, 4);
    check("gate_to ref", m_ref, 150);
    check("gate_to timeout", m_to, 1);
    check("gate_to ovf", m_ovf, 0);

    // 8-bit instance: ref saturates before the 300-cycle gate timeout
    do_reset();
    ticks(5);
    gen(2, 11);
    wait_valid("sat", 2, 600, n);
    check("sat sig", s_sig, 10);
    check("sat ref", s_ref, 255);
    check("sat ovf", s_ovf, 1);
    check("sat timeout", s_to, 1);
    tick();
    wait_valid("sat_next", 2, 400, n);
    check("sat_next ovf cleared", s_ovf, 0);
    check("sat_next ref", s_ref, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
